// File: rtl/ldpc_stream_collector.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_stream_collector
// Purpose  : Captures the LDPC core's column stream and packs it, right-aligned
//            to the block size, into one codeword held under valid/ready.
//            Optional overrun detection is enabled with LDPC_COLLECT_OVERRUN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ldpc_stream_collector #(
    parameter  int MAX_BLOCK_SIZE = 64,
    parameter  int MAX_COLS       = 24,
    localparam int MAX_CODE_LEN   = MAX_COLS * MAX_BLOCK_SIZE,
    localparam int WIDTH_COLS     = $clog2(MAX_COLS + 1),
    localparam int WIDTH_BSZ      = $clog2(MAX_BLOCK_SIZE + 1),
    localparam int WIDTH_CODE_LEN = $clog2(MAX_CODE_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_valid,
    input  logic [WIDTH_COLS-1:0]     cfg_cols,
    input  logic [WIDTH_BSZ-1:0]      cfg_block_size,
    input  logic                      src_done,
    input  logic                      src_valid,
    input  logic [MAX_BLOCK_SIZE-1:0] src_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAX_CODE_LEN-1:0]   out_codeword,
    output logic [WIDTH_CODE_LEN-1:0] out_len,
    output logic                      out_dec_valid,
    output logic                      busy,
    output logic                      overrun_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [WIDTH_COLS-1:0]     cnt_q, cnt_d;
    logic [WIDTH_COLS-1:0]     cols_q, cols_d;
    logic [WIDTH_BSZ-1:0]      bs_q, bs_d;
    logic [WIDTH_CODE_LEN-1:0] len_q, len_d;
    logic [MAX_CODE_LEN-1:0]   code_q, code_d;
    logic                      dec_q, dec_d;
    logic                      w_start;

    logic [WIDTH_BSZ-1:0]      w_shift;
    logic [MAX_BLOCK_SIZE-1:0] w_word;
    logic [WIDTH_CODE_LEN-1:0] w_offset;
    logic [MAX_CODE_LEN-1:0]   w_place;

    // Right shift zero-fills, so w_word is already masked to bs bits and can
    // be OR-ed into a codeword that was cleared when the capture started.
    assign w_shift  = WIDTH_BSZ'(MAX_BLOCK_SIZE) - bs_q;
    assign w_word   = src_data >> w_shift;
    assign w_offset = WIDTH_CODE_LEN'(cnt_q) * WIDTH_CODE_LEN'(bs_q);
    assign w_place  = {{(MAX_CODE_LEN-MAX_BLOCK_SIZE){1'b0}}, w_word} << w_offset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cols_d  = cols_q;
        bs_d    = bs_q;
        len_d   = len_q;
        code_d  = code_q;
        dec_d   = dec_q;
        w_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_valid) begin
                    cols_d = cfg_cols;
                    bs_d   = cfg_block_size;
                    len_d  = WIDTH_CODE_LEN'(cfg_cols) * WIDTH_CODE_LEN'(cfg_block_size);
                    code_d = '0;
                end
                if (src_done) begin
                    w_start = 1'b1;
                end
            end
            S_COLLECT: begin
                if (cnt_q < cols_q) begin
                    code_d = code_q | w_place;
                end
                if (cnt_q == WIDTH_COLS'(MAX_COLS - 1)) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                // A done arriving with the handshake starts the next capture at once.
                if (out_ready) begin
                    state_d = S_IDLE;
                    if (src_done) begin
                        w_start = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_start) begin
            state_d = S_COLLECT;
            cnt_d   = '0;
            code_d  = '0;
            dec_d   = src_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cols_q  <= '0;
            bs_q    <= '0;
            len_q   <= '0;
            code_q  <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cols_q  <= cols_d;
            bs_q    <= bs_d;
            len_q   <= len_d;
            code_q  <= code_d;
            dec_q   <= dec_d;
        end
    end

`ifdef LDPC_COLLECT_OVERRUN_EN
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (state_q == S_IDLE && cfg_valid) begin
            ovr_d = 1'b0;
        end else if (src_done &&
                     (state_q == S_COLLECT || (state_q == S_HOLD && !out_ready))) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_err = ovr_q;
`else
    assign overrun_err = 1'b0;
`endif

    assign out_valid     = (state_q == S_HOLD);
    assign busy          = (state_q == S_COLLECT);
    assign out_codeword  = code_q;
    assign out_len       = len_q;
    assign out_dec_valid = dec_q;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_stream_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldpc_stream_collector
// Purpose  : Self-checking bench for ldpc_stream_collector: vector table, corner
//            sequences and randomized captures against a bit-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldpc_stream_collector;

    localparam int MBS = 64;
    localparam int MC  = 24;
    localparam int CL  = MC * MBS;

`ifdef LDPC_COLLECT_OVERRUN_EN
    localparam bit EXP_OVR = 1'b1;
`else
    localparam bit EXP_OVR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic [4:0]    cfg_cols;
    logic [6:0]    cfg_block_size;
    logic          src_done;
    logic          src_valid;
    logic [63:0]   src_data;
    logic          out_valid;
    logic          out_ready;
    logic [CL-1:0] out_codeword;
    logic [10:0]   out_len;
    logic          out_dec_valid;
    logic          busy;
    logic          overrun_err;

    always #5 clk = ~clk;

    ldpc_stream_collector #(
        .MAX_BLOCK_SIZE (MBS),
        .MAX_COLS       (MC)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid      (cfg_valid),
        .cfg_cols       (cfg_cols),
        .cfg_block_size (cfg_block_size),
        .src_done       (src_done),
        .src_valid      (src_valid),
        .src_data       (src_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_codeword   (out_codeword),
        .out_len        (out_len),
        .out_dec_valid  (out_dec_valid),
        .busy           (busy),
        .overrun_err    (overrun_err)
    );

    typedef struct {
        int cols;
        int bs;
        int pat;
        bit sv;
        int exp_len;
        bit exp_dec;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] words [MC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cw(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
        int ndiff;
        int first;
        tests++;
        if (act !== exp) begin
            fails++;
            ndiff = 0;
            first = -1;
            for (int i = 0; i < CL; i++) begin
                if (act[i] !== exp[i]) begin
                    ndiff++;
                    if (first < 0) first = i;
                end
            end
            $display("FAIL %s: codeword differs in %0d bits, first at bit %0d (got %b expected %b)",
                     name, ndiff, first, act[first], exp[first]);
        end
    endtask

    // Reference: column k keeps the top bs bits of word k, placed at k*bs.
    function automatic logic [CL-1:0] model_cw(input int cols, input int bs);
        logic [CL-1:0] r;
        r = '0;
        for (int k = 0; k < cols; k++) begin
            for (int b = 0; b < bs; b++) begin
                r[k*bs + b] = words[k][MBS - bs + b];
            end
        end
        return r;
    endfunction

    task automatic fill_words(input int pat, input int bs);
        for (int k = 0; k < MC; k++) begin
            case (pat)
                0:       words[k] = 64'(k*3 + 1) << (MBS - bs);
                1:       words[k] = '1;
                default: words[k] = {$urandom, $urandom};
            endcase
        end
    endtask

    task automatic do_config(input int cols, input int bs);
        @(negedge clk);
        cfg_valid      = 1'b1;
        cfg_cols       = 5'(cols);
        cfg_block_size = 7'(bs);
        @(negedge clk);
        cfg_valid      = 1'b0;
    endtask

    // Presents words[0..MC-1] on consecutive cycles; the caller raised src_done
    // at the previous negedge. Ends at the negedge after the last word.
    task automatic stream(input int inject_at, output bit busy_ok);
        busy_ok = 1'b1;
        for (int k = 0; k < MC; k++) begin
            @(negedge clk);
            if (!(busy === 1'b1 && out_valid === 1'b0)) busy_ok = 1'b0;
            src_done  = (k == inject_at);
            src_valid = 1'b1;
            src_data  = words[k];
            out_ready = 1'b0;
        end
        @(negedge clk);
        src_done = 1'b0;
        src_data = '0;
    endtask

    task automatic capture(input int cols, input int bs, input bit sv, input int bp,
                           input int inject, input int exp_len, input bit exp_dec,
                           input string tag);
        logic [CL-1:0] exp;
        bit            ok;
        do_config(cols, bs);
        exp = model_cw(cols, bs);
        @(negedge clk);
        src_done  = 1'b1;
        src_valid = sv;
        stream(inject, ok);
        check({tag, ":busy_window"}, 64'(ok), 64'd1);
        check({tag, ":valid_rise"}, 64'(out_valid), 64'd1);
        repeat (bp) @(negedge clk);
        check_cw({tag, ":codeword"}, out_codeword, exp);
        check({tag, ":len"}, 64'(out_len), 64'(exp_len));
        check({tag, ":dec_valid"}, 64'(out_dec_valid), 64'(exp_dec));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ":valid_drop"}, 64'(out_valid | busy), 64'd0);
    endtask

    initial begin
        vec_t          tbl [6];
        logic [CL-1:0] exp_a, exp_b;
        bit            ok;
        int            rc, rb;

        tbl[0] = '{cols: 24, bs: 57, pat: 0, sv: 1'b1, exp_len: 1368, exp_dec: 1'b1};
        tbl[1] = '{cols: 12, bs: 64, pat: 1, sv: 1'b1, exp_len: 768,  exp_dec: 1'b1};
        tbl[2] = '{cols: 24, bs: 64, pat: 2, sv: 1'b0, exp_len: 1536, exp_dec: 1'b0};
        tbl[3] = '{cols: 1,  bs: 1,  pat: 2, sv: 1'b1, exp_len: 1,    exp_dec: 1'b1};
        tbl[4] = '{cols: 5,  bs: 33, pat: 2, sv: 1'b0, exp_len: 165,  exp_dec: 1'b0};
        tbl[5] = '{cols: 24, bs: 1,  pat: 1, sv: 1'b1, exp_len: 24,   exp_dec: 1'b1};

        rst_n          = 1'b0;
        cfg_valid      = 1'b0;
        cfg_cols       = '0;
        cfg_block_size = '0;
        src_done       = 1'b0;
        src_valid      = 1'b0;
        src_data       = '0;
        out_ready      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset:out_valid", 64'(out_valid), 64'd0);
        check("reset:busy", 64'(busy), 64'd0);
        check_cw("reset:codeword", out_codeword, '0);
        check("reset:len", 64'(out_len), 64'd0);
        check("reset:dec_valid", 64'(out_dec_valid), 64'd0);
        check("reset:overrun", 64'(overrun_err), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            fill_words(tbl[i].pat, tbl[i].bs);
            capture(tbl[i].cols, tbl[i].bs, tbl[i].sv, i % 3, -1,
                    tbl[i].exp_len, tbl[i].exp_dec, $sformatf("vec%0d", i));
        end

        // Backpressure: a second stream arriving in HOLD is dropped.
        fill_words(2, 64);
        do_config(24, 64);
        exp_a = model_cw(24, 64);
        @(negedge clk);
        src_done = 1'b1;
        src_valid = 1'b1;
        stream(-1, ok);
        check("drop:valid_rise", 64'(out_valid), 64'd1);
        repeat (2) @(negedge clk);
        fill_words(1, 64);
        src_done = 1'b1;
        stream(-1, ok);
        check("drop:still_valid", 64'(out_valid), 64'd1);
        check_cw("drop:codeword_held", out_codeword, exp_a);
        check("drop:overrun", 64'(overrun_err), 64'(EXP_OVR));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        do_config(3, 8);
        check("drop:overrun_cleared", 64'(overrun_err), 64'd0);

        // src_done during COLLECT is ignored; capture completes unchanged.
        fill_words(2, 20);
        capture(17, 20, 1'b1, 0, 5, 340, 1'b1, "collect_done");
        check("collect_done:overrun", 64'(overrun_err), 64'(EXP_OVR));
        do_config(17, 20);
        check("collect_done:overrun_cleared", 64'(overrun_err), 64'd0);

        // Handshake and src_done in the same HOLD cycle.
        fill_words(2, 40);
        do_config(20, 40);
        exp_a = model_cw(20, 40);
        @(negedge clk);
        src_done = 1'b1;
        src_valid = 1'b1;
        stream(-1, ok);
        check("simul:first_valid", 64'(out_valid), 64'd1);
        check_cw("simul:first_codeword", out_codeword, exp_a);
        fill_words(2, 40);
        exp_b = model_cw(20, 40);
        out_ready = 1'b1;
        src_done  = 1'b1;
        src_valid = 1'b0;
        stream(-1, ok);
        check("simul:restart_busy", 64'(ok), 64'd1);
        check("simul:second_valid", 64'(out_valid), 64'd1);
        check_cw("simul:second_codeword", out_codeword, exp_b);
        check("simul:second_dec", 64'(out_dec_valid), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset asserted while word 10 is on the bus.
        fill_words(1, 64);
        do_config(24, 64);
        @(negedge clk);
        src_done = 1'b1;
        src_valid = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            src_done = 1'b0;
            src_data = words[k];
            if (k == 10) rst_n = 1'b0;
        end
        @(negedge clk);
        check("midrst:busy", 64'(busy), 64'd0);
        check("midrst:out_valid", 64'(out_valid), 64'd0);
        check_cw("midrst:codeword", out_codeword, '0);
        check("midrst:len", 64'(out_len), 64'd0);
        rst_n = 1'b1;
        fill_words(2, 50);
        capture(10, 50, 1'b1, 1, -1, 500, 1'b1, "after_rst");

        for (int it = 0; it < 20; it++) begin
            rc = $urandom_range(1, MC);
            rb = $urandom_range(1, MBS);
            fill_words(2, rb);
            ok = 1'($urandom_range(0, 1));
            capture(rc, rb, ok, $urandom_range(0, 3), -1, rc*rb, ok,
                    $sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ldpc_stream_collector.md
# ldpc_stream_collector

Host-side receiver for the block-serial output stream of `ldpc_encoder` / `ldpc_decoder`. After the core pulses `done`, the core presents `MAX_COLS` left-justified column words on `data_out`. This block captures those words, right-aligns each to the configured block size and packs them into one flat codeword register. It then holds the result under a valid/ready handshake so downstream logic never has to track the core's streaming cadence.

## Interface
Parameters:
- `MAX_BLOCK_SIZE`, 64, lifting size upper bound; column word width
- `MAX_COLS`, 24, maximum base-matrix columns
- `MAX_CODE_LEN`, `MAX_COLS*MAX_BLOCK_SIZE` (localparam), packed codeword width
- `WIDTH_COLS`, `$clog2(MAX_COLS+1)` (localparam)
- `WIDTH_BSZ`, `$clog2(MAX_BLOCK_SIZE+1)` (localparam)
- `WIDTH_CODE_LEN`, `$clog2(MAX_CODE_LEN+1)` (localparam)

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  synchronous, active-low reset
- `cfg_valid`  in  1  load `cfg_cols`/`cfg_block_size`
- `cfg_cols`  in  WIDTH_COLS  active columns, 1..MAX_COLS
- `cfg_block_size`  in  WIDTH_BSZ  lifting size, 1..MAX_BLOCK_SIZE
- `src_done`  in  1  core `done` pulse
- `src_valid`  in  1  core `valid` flag (decoder only; tie 1 for encoder)
- `src_data`  in  MAX_BLOCK_SIZE  core `data_out` word, MSB-justified
- `out_valid`  out  1  packed codeword available
- `out_ready`  in  1  downstream accepts
- `out_codeword`  out  MAX_CODE_LEN  packed codeword; column i at `[i*bs +: bs]`
- `out_len`  out  WIDTH_CODE_LEN  `cols*bs`
- `out_dec_valid`  out  1  `src_valid` sampled on the `src_done` cycle
- `busy`  out  1  high in COLLECT
- `overrun_err`  out  1  sticky overrun flag (see Configuration)

## Operation
- States: IDLE, COLLECT, HOLD.
- **IDLE**
  - `cfg_valid` latches cols/bs. Config is ignored in every other state.
  - `src_done` clears `out_codeword`, samples `src_valid` into `out_dec_valid`, zeroes the column counter, then goes to COLLECT.
- **COLLECT**
  - Each cycle consumes one `src_data` word for column index `k`.
  - If `k < cols`, `out_codeword[k*bs +: bs] <= src_data >> (MAX_BLOCK_SIZE-bs)`.
  - Words with `k >= cols` are discarded. The counter still runs to MAX_COLS-1.
  - After word `MAX_COLS-1`, go to HOLD.
- **HOLD**
  - `out_valid=1` while in HOLD.
  - `out_valid && out_ready` completes the transfer and returns to IDLE.
- Bits of `out_codeword` at or above `cols*bs` are always 0.
- `out_len` is computed at config load and registered.
- **Boundary conditions**
  - `src_done` in COLLECT is ignored; the current capture continues.
  - `src_done` in HOLD without handshake: the stream is dropped and the held data is unchanged.
  - `src_done` in HOLD on the same cycle as the handshake: treat as IDLE, so the result is accepted and a new COLLECT starts with no loss.
  - `bs = MAX_BLOCK_SIZE`: shift by 0.
  - `cfg_cols = 0` or `cfg_block_size = 0`: illegal, and behaviour is unspecified.
- **Reset** (also mid-COLLECT or mid-HOLD): state IDLE, all outputs 0, cols/bs 0, counter 0. A capture in progress is lost.

## Timing
- `src_done` high at cycle T. Word k is sampled at T+1+k, for k = 0..MAX_COLS-1.
- `out_valid` rises at T+MAX_COLS+1. `busy` is high during T+1..T+MAX_COLS.
- `out_codeword`, `out_len` and `out_dec_valid` are stable for the whole time `out_valid` is high.
- `out_valid` drops the cycle after the handshake.
- Minimum done-to-done spacing without loss: MAX_COLS+1 cycles, with `out_ready` held high.

## Configuration
- Macro: `LDPC_COLLECT_OVERRUN_EN`.
- Defined:
  - `overrun_err` sets on any ignored `src_done`, i.e. in COLLECT, or in HOLD without handshake.
  - The flag is sticky and is cleared only by `cfg_valid` in IDLE or by reset.
- Undefined: `overrun_err` is tied 0, with no detection logic. Drop behaviour is identical.

## Test plan
- Basic capture:
  - Stimulus: cols=24, bs=57, `src_done`, then word k = `{57'(k*3+1), 7'b0}`, with `out_ready=1`.
  - Required: `out_valid` at T+25; `out_codeword[k*57 +: 57] == k*3+1`; `out_len=1368`; then IDLE.
- Partial columns:
  - Stimulus: cols=12, bs=64, all words `64'hFFFF_FFFF_FFFF_FFFF`.
  - Required: bits [767:0] all 1, bits [1535:768] all 0, `out_len=768`.
- Backpressure and drop:
  - Stimulus: `out_ready=0` in HOLD, second `src_done` with different data.
  - Required: held codeword unchanged; `overrun_err=1` with the macro, 0 without.
- Simultaneous handshake:
  - Stimulus: `out_ready` and `src_done` in the same HOLD cycle.
  - Required: first result accepted; second captured, with `out_valid` again MAX_COLS+1 cycles later.
- Decoder flag:
  - Stimulus: `src_valid=0` at `src_done`, 1 afterwards.
  - Required: `out_dec_valid=0` in HOLD.
- Mid-stream reset:
  - Stimulus: `rst_n=0` at word 10.
  - Required: next cycle `busy=0`, `out_valid=0`, `out_codeword=0`, `out_len=0`; a following config plus `src_done` captures normally.
